ark_stage: RTL

ARK_STAGE -- requirements
Module: ark_stage

---
 rtl/ark_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/ark_stage.sv
// ark_stage: AES-128 AddRoundKey stage with on-the-fly key expansion and valid/ready handshake.
// Define ARK_ROUNDKEY_OUT_EN to add the registered round_key_out port.
module ark_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = TBL[2047 - 8 * int'(a) -: 8];
endmodule

module ark_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [3:0]   round,
  output logic         done
`ifdef ARK_ROUNDKEY_OUT_EN
  ,
  output logic [127:0] round_key_out
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [127:0] key_reg;
  logic [31:0] rot, sub, w4, w5, w6, w7;
  logic [7:0] rcon;
  logic xfer, last;
  assign xfer = in_valid & in_ready;
  assign last = round == 4'(NR);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = start ? RUN : (xfer && last) ? IDLE : state;
  always_comb in_ready = (state == RUN) & (!out_valid | out_ready) & !start;
  // SubWord(RotWord(w3)), w3 being the low word of the current key
  assign rot = {key_reg[23:0], key_reg[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sb
    ark_sbox u_sb (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end
  always_comb
    case (round)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  assign w4 = key_reg[127:96] ^ sub ^ {rcon, 24'h0};
  assign w5 = key_reg[95:64] ^ w4;
  assign w6 = key_reg[63:32] ^ w5;
  assign w7 = key_reg[31:0] ^ w6;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_reg   <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      state_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= xfer & last;
      if (start) begin
        key_reg   <= key_in;
        round     <= '0;
        out_valid <= 1'b0;
      end else if (xfer) begin
        state_out <= state_in ^ key_reg;
        out_valid <= 1'b1;
        if (!last) begin
          key_reg <= {w4, w5, w6, w7};
          round   <= round + 4'd1;
        end
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef ARK_ROUNDKEY_OUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) round_key_out <= '0;
    else if (xfer) round_key_out <= key_reg;
`endif
endmodule
